// File: rtl/johnson_counter.sv
// Johnson (twisted-ring) counter with one-hot and binary phase decode,
// wrap flag and illegal-state detection with self-correction to all-zero.

// Flags when the counter holds the Johnson state with index IDX.
module johnson_state_match #(
    parameter int WIDTH = 4,
    parameter int IDX   = 0
) (
    input  logic [WIDTH-1:0] state,
    output logic             hit
);
    // State k: k low ones for k<=WIDTH, otherwise ones with (k-WIDTH) low zeros.
    function automatic logic [WIDTH-1:0] pattern(input int k);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (k <= WIDTH) p[i] = (i < k);
            else            p[i] = (i >= k - WIDTH);
        end
        return p;
    endfunction

    localparam logic [WIDTH-1:0] PAT = pattern(IDX);

    assign hit = (state == PAT);
endmodule

module johnson_counter #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [WIDTH-1:0]              out,
    output logic [2*WIDTH-1:0]            phase,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          wrap,
    output logic                          illegal
);
    localparam int STATES = 2 * WIDTH;
    localparam int IDX_W  = $clog2(STATES);

    logic [WIDTH-1:0]  out_q, out_d;
    logic [STATES-1:0] hit;
    logic [IDX_W-1:0]  idx_c;

    // One comparator per valid state; at most one can hit.
    for (genvar g = 0; g < STATES; g++) begin : g_match
        johnson_state_match #(
            .WIDTH (WIDTH),
            .IDX   (g)
        ) u_match (
            .state (out_q),
            .hit   (hit[g])
        );
    end

    // Convert the one-hot hit vector to a binary index (zero when no hit).
    always_comb begin
        idx_c = '0;
        for (int k = 0; k < STATES; k++) begin
            if (hit[k]) idx_c = idx_c | IDX_W'(k);
        end
    end

    // Next state: twisted shift, or jump to all-zero from any illegal state.
    always_comb begin
        out_d = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
        if (illegal) out_d = '0;
    end

    // State register; reset dominates counting and self-correction.
    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign out       = out_q;
    assign phase     = hit;
    assign phase_idx = idx_c;
    assign wrap      = hit[STATES-1];
    assign illegal   = ~|hit;
endmodule

// File: tb/tb_johnson_counter.sv
module tb_johnson_counter;
    logic       clk;
    logic       rst;
    logic [3:0] out;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       wrap;
    logic       illegal;

    logic       rst3;
    logic [2:0] out3;
    logic [5:0] phase3;
    logic [2:0] phase_idx3;
    logic       wrap3;
    logic       illegal3;

    int n_tests = 0;
    int n_fail  = 0;

    johnson_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .out(out), .phase(phase),
        .phase_idx(phase_idx), .wrap(wrap), .illegal(illegal)
    );

    johnson_counter #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst3), .out(out3), .phase(phase3),
        .phase_idx(phase_idx3), .wrap(wrap3), .illegal(illegal3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] out;
        logic [2:0] idx;
        logic       wrap;
    } vec_t;

    typedef struct {
        logic [2:0] out;
        logic [2:0] idx;
        logic       wrap;
    } vec3_t;

    vec_t  vecs  [12];
    vec3_t vecs3 [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_w4(input string tag, input vec_t v);
        logic [7:0] ph;
        ph = 8'd1 << v.idx;
        chk({tag, ".out"},       32'(out),       32'(v.out));
        chk({tag, ".phase"},     32'(phase),     32'(ph));
        chk({tag, ".phase_idx"}, 32'(phase_idx), 32'(v.idx));
        chk({tag, ".wrap"},      32'(wrap),      32'(v.wrap));
        chk({tag, ".illegal"},   32'(illegal),   32'd0);
    endtask

    initial begin
        vec_t v;
        // Expected state after edges at t=25,35,...,135.
        vecs[0]  = '{4'b0000, 3'd0, 1'b0};
        vecs[1]  = '{4'b0000, 3'd0, 1'b0};
        vecs[2]  = '{4'b0001, 3'd1, 1'b0};
        vecs[3]  = '{4'b0011, 3'd2, 1'b0};
        vecs[4]  = '{4'b0111, 3'd3, 1'b0};
        vecs[5]  = '{4'b1111, 3'd4, 1'b0};
        vecs[6]  = '{4'b1110, 3'd5, 1'b0};
        vecs[7]  = '{4'b1100, 3'd6, 1'b0};
        vecs[8]  = '{4'b1000, 3'd7, 1'b1};
        vecs[9]  = '{4'b0000, 3'd0, 1'b0};
        vecs[10] = '{4'b0001, 3'd1, 1'b0};
        vecs[11] = '{4'b0011, 3'd2, 1'b0};

        vecs3[0] = '{3'b001, 3'd1, 1'b0};
        vecs3[1] = '{3'b011, 3'd2, 1'b0};
        vecs3[2] = '{3'b111, 3'd3, 1'b0};
        vecs3[3] = '{3'b110, 3'd4, 1'b0};
        vecs3[4] = '{3'b100, 3'd5, 1'b1};
        vecs3[5] = '{3'b000, 3'd0, 1'b0};
        vecs3[6] = '{3'b001, 3'd1, 1'b0};

        rst  = 1'b0;
        rst3 = 1'b1;
        #20 rst = 1'b1;
        @(posedge clk); #1;          // edge 25
        chk_w4("e25", vecs[0]);
        @(posedge clk); #1;          // edge 35
        chk_w4("e35", vecs[1]);
        #4 rst = 1'b0;               // t=40
        for (int i = 2; i < 12; i++) begin
            @(posedge clk); #1;
            chk_w4($sformatf("e%0d", 25 + 10 * i), vecs[i]);
        end

        // Reset asserted mid-sequence at 0111.
        @(posedge clk); #1;
        chk("mid.pre_out", 32'(out), 32'h7);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid.rst_out", 32'(out), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid.resume_out", 32'(out), 32'h1);

        // Forced illegal state self-corrects to zero, then counts normally.
        force dut.out_q = 4'b0101;
        #1;
        chk("ill.illegal",   32'(illegal),   32'd1);
        chk("ill.phase",     32'(phase),     32'd0);
        chk("ill.phase_idx", 32'(phase_idx), 32'd0);
        chk("ill.wrap",      32'(wrap),      32'd0);
        release dut.out_q;
        @(posedge clk); #1;
        chk("ill.fix_out", 32'(out), 32'h0);
        chk("ill.fix_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        chk("ill.next1", 32'(out), 32'h1);
        @(posedge clk); #1;
        chk("ill.next2", 32'(out), 32'h3);

        // Illegal state while reset is held.
        rst = 1'b1;
        force dut.out_q = 4'b0110;
        #1;
        chk("rstill.illegal", 32'(illegal), 32'd1);
        release dut.out_q;
        @(posedge clk); #1;
        chk("rstill.out", 32'(out), 32'h0);
        @(posedge clk); #1;
        chk("rstill.hold", 32'(out), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstill.resume", 32'(out), 32'h1);

        // WIDTH=3 instance, held in reset until now.
        chk("w3.rst_out",  32'(out3),   32'h0);
        chk("w3.rst_phase", 32'(phase3), 32'h1);
        chk("w3.rst_wrap", 32'(wrap3),  32'd0);
        rst3 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk($sformatf("w3[%0d].out", i),  32'(out3),       32'(vecs3[i].out));
            chk($sformatf("w3[%0d].idx", i),  32'(phase_idx3), 32'(vecs3[i].idx));
            chk($sformatf("w3[%0d].ph", i),   32'(phase3),     32'(6'd1 << vecs3[i].idx));
            chk($sformatf("w3[%0d].wrap", i), 32'(wrap3),      32'(vecs3[i].wrap));
            chk($sformatf("w3[%0d].ill", i),  32'(illegal3),   32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
